// File: rtl/const_div_iter.sv
// Iterative unsigned divide-by-constant: retires CHUNK dividend bits per cycle,
// most-significant slice first, carrying the partial remainder forward.
module const_div_iter #(
    parameter int WIDTH   = 24,
    parameter int DIVISOR = 113,
    parameter int CHUNK   = 4,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [RW-1:0]    out_r
);

    localparam int STEPS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int SW    = STEPS * CHUNK;
    localparam int TW    = RW + CHUNK;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("const_div_iter: DIVISOR must be at least 2");
    end
    if (CHUNK < 1 || CHUNK > 8) begin : g_bad_chunk
        $error("const_div_iter: CHUNK must be in 1..8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     sr;
    logic [WIDTH-1:0]  q;
    logic [RW-1:0]     rem;
    logic [CW-1:0]     cnt;
    logic [CHUNK-1:0]  digit;
    logic [RW-1:0]     rem_nx;
    logic              accept;

    // Constant divide of a TW-bit partial dividend; since the incoming
    // remainder is below DIVISOR the quotient digit always fits in CHUNK bits.
    function automatic logic [TW-1:0] divstep(input logic [TW-1:0] t);
        return {CHUNK'(t / DIV_T), RW'(t % DIV_T)};
    endfunction

    always_comb begin
        {digit, rem_nx} = divstep({rem, sr[SW-1 -: CHUNK]});
    end

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = RUN;
            RUN:  if (cnt == CW'(1)) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (accept) begin
            q   <= '0;
            rem <= '0;
            cnt <= CW'(STEPS);
        end else if (state == RUN) begin
            // Quotient padding bits above WIDTH are always zero, so truncation is lossless.
            q   <= WIDTH'({q, digit});
            rem <= rem_nx;
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sr <= SW'(in_x);
        end else if (state == RUN) begin
            sr <= sr << CHUNK;
        end
    end

    assign out_q = q;
    assign out_r = rem;

endmodule

// File: tb/tb_const_div_iter.sv
// Bench for const_div_iter: directed cases plus random dividends over four
// divisor/chunk configurations, checked against plain integer division.
module tb_const_div_iter;

    localparam int NK = 4;
    localparam int DIVS [NK] = '{113, 113, 3, 255};
    localparam int CHS  [NK] = '{4, 5, 1, 8};
    localparam int STP  [NK] = '{6, 5, 24, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NK];
    logic        in_ready  [NK];
    logic [23:0] in_x      [NK];
    logic        out_valid [NK];
    logic        out_ready [NK];
    logic [23:0] out_q     [NK];
    logic [7:0]  out_r     [NK];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        localparam int RWG = $clog2(DIVS[g]);
        logic [RWG-1:0] r_w;
        const_div_iter #(.WIDTH(24), .DIVISOR(DIVS[g]), .CHUNK(CHS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_x      (in_x[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_q     (out_q[g]),
            .out_r     (r_w)
        );
        assign out_r[g] = 8'(r_w);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k, optionally stalling hold cycles in DONE.
    task automatic txn(input int k, input logic [23:0] x, input int hold);
        logic [23:0] eq;
        logic [7:0]  er;
        int          lat;
        int          w;
        logic        busy_bad;
        eq = 24'(int'(x) / DIVS[k]);
        er = 8'(int'(x) % DIVS[k]);
        w = 0;
        while (in_ready[k] !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_idle", 64'(in_ready[k]), 64'd1);
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_x[k]     = x;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_x[k]     = 24'($urandom);
        lat = 0;
        busy_bad = 1'b0;
        while (out_valid[k] !== 1'b1 && lat < 200) begin
            if (in_ready[k] !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'(STP[k]));
        chk("busy_in_ready", 64'(busy_bad), 64'd0);
        chk("quotient", 64'(out_q[k]), 64'(eq));
        chk("remainder", 64'(out_r[k]), 64'(er));
        chk("in_ready_done", 64'(in_ready[k]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid[k] = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_stable", {31'd0, out_valid[k], in_ready[k], out_q[k], out_r[k]},
                {31'd0, 1'b1, 1'b0, eq, er});
        end
        @(negedge clk);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        chk("release", {62'd0, in_ready[k], out_valid[k]}, 64'b10);
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        logic spurious;
        rst_n = 1'b0;
        for (int k = 0; k < NK; k++) begin
            in_valid[k]  = 1'b0;
            in_x[k]      = '0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {30'd0, in_ready[0], out_valid[0], out_q[0], out_r[0]},
            {30'd0, 1'b1, 1'b0, 24'd0, 8'd0});
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 24'd0, 0);
        txn(0, 24'd113, 0);
        txn(0, 24'd112, 0);
        txn(0, 24'hFFFFFF, 0);
        txn(0, 24'd1000000, 10);

        // Reset asserted during the third RUN cycle.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_x[0]     = 24'd1000000;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", {62'd0, in_ready[0], out_valid[0]}, 64'b10);
        @(posedge clk); #1;
        chk("reset_clear", {32'd0, out_q[0], out_r[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) spurious = 1'b1;
        end
        chk("no_spurious", 64'(spurious), 64'd0);
        txn(0, 24'd226, 0);

        txn(1, 24'd1000000, 0);
        txn(1, 24'hFFFFFF, 0);

        for (int k = 0; k < NK; k++) begin
            txn(k, 24'd0, 0);
            txn(k, 24'hFFFFFF, 1);
            repeat (300) txn(k, 24'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
